// File: rtl/fifo_access_arb_if.sv
// Access bus between the FIFO requesters/consumer and fifo_access_arb.
// master = requester/FIFO side, slave = the arbiter.
interface fifo_access_arb_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic [DATA_WIDTH-1:0] din0;
  logic                  req1;
  logic [DATA_WIDTH-1:0] din1;
  logic                  req_rd;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_rd;
  logic                  fifo_wr_en;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic [3:0]            count;
  logic                  full;
  logic                  empty;
  logic                  err;

  modport master (
    output req0, din0, req1, din1, req_rd,
    input  gnt0, gnt1, gnt_rd, fifo_wr_en, fifo_rd_en, fifo_din,
           count, full, empty, err
  );

  modport slave (
    input  req0, din0, req1, din1, req_rd,
    output gnt0, gnt1, gnt_rd, fifo_wr_en, fifo_rd_en, fifo_din,
           count, full, empty, err
  );
endinterface

// File: rtl/fifo_access_arb.sv
// Round-robin scheduler sharing one FIFO access per cycle among two writers and one reader.
// Optional blocked-request pulse on err: define FIFO_ACCESS_ARB_ERR_EN.
module fifo_access_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input logic              clk,
  input logic              reset_n,
  fifo_access_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WR0, WR1, RD} state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t                r_state;
  state_t                w_state_next;
  state_t                r_last;
  state_t                w_last_next;
  logic [3:0]            r_count;
  logic [3:0]            w_count_next;
  logic                  w_full_next;
  logic                  w_empty_next;
  logic                  w_elig_w0;
  logic                  w_elig_w1;
  logic                  w_elig_rd;
  logic                  r_full;
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_gnt_rd;
  logic                  r_wr_en;
  logic                  r_rd_en;

  // Occupancy once the access being driven this cycle has completed.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_count_next = r_count;
    case (r_state)
      WR0, WR1: w_count_next = r_count + 4'd1;
      RD:       w_count_next = r_count - 4'd1;
      default:  w_count_next = r_count;
    endcase
    w_full_next  = (w_count_next == DEPTH_C);
    w_empty_next = (w_count_next == 4'd0);
    w_elig_w0    = bus.req0   & ~w_full_next  & (r_state != WR0);
    w_elig_w1    = bus.req1   & ~w_full_next  & (r_state != WR1);
    w_elig_rd    = bus.req_rd & ~w_empty_next & (r_state != RD);
  end

  // Search starts just after the last granted requester: W0 -> W1 -> RD -> W0.
  always_comb begin
    w_state_next = IDLE;
    case (r_last)
      WR0: begin
        if      (w_elig_w1) w_state_next = WR1;
        else if (w_elig_rd) w_state_next = RD;
        else if (w_elig_w0) w_state_next = WR0;
      end
      WR1: begin
        if      (w_elig_rd) w_state_next = RD;
        else if (w_elig_w0) w_state_next = WR0;
        else if (w_elig_w1) w_state_next = WR1;
      end
      default: begin
        if      (w_elig_w0) w_state_next = WR0;
        else if (w_elig_w1) w_state_next = WR1;
        else if (w_elig_rd) w_state_next = RD;
      end
    endcase
    w_last_next = (w_state_next == IDLE) ? r_last : w_state_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_last   <= RD;
      r_count  <= 4'd0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_din    <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_gnt_rd <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_last   <= w_last_next;
      r_count  <= w_count_next;
      r_full   <= w_full_next;
      r_empty  <= w_empty_next;
      r_gnt0   <= (w_state_next == WR0);
      r_gnt1   <= (w_state_next == WR1);
      r_gnt_rd <= (w_state_next == RD);
      r_wr_en  <= (w_state_next == WR0) | (w_state_next == WR1);
      r_rd_en  <= (w_state_next == RD);
      if (w_state_next == WR0)
        r_din <= bus.din0;
      else if (w_state_next == WR1)
        r_din <= bus.din1;
    end
  end

  // Strobes are dedicated flops rather than state decodes, so outputs stay glitch-free.
  assign bus.gnt0       = r_gnt0;
  assign bus.gnt1       = r_gnt1;
  assign bus.gnt_rd     = r_gnt_rd;
  assign bus.fifo_wr_en = r_wr_en;
  assign bus.fifo_rd_en = r_rd_en;
  assign bus.fifo_din   = r_din;
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;

`ifdef FIFO_ACCESS_ARB_ERR_EN
  logic r_err;

  // A request that the occupancy rules cannot honour this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= 1'b0;
    else
      r_err <= ((bus.req0 | bus.req1) & w_full_next) | (bus.req_rd & w_empty_next);
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_access_arb.sv
// Self-checking bench for fifo_access_arb: directed table, corner sequences and
// randomized traffic checked against a behavioural occupancy/rotation model.
module tb_fifo_access_arb;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
`ifdef FIFO_ACCESS_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_access_arb_if #(.DATA_WIDTH(DW)) bus ();

  fifo_access_arb #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant index 0=W0, 1=W1, 2=RD, 3=none.
  int              m_grant;
  int              m_last;
  int              m_count;
  logic [DW-1:0]   m_din;
  bit              m_err;

  int n_g0, n_g1, n_grd;

  task automatic model_reset();
    m_grant = 3;
    m_last  = 2;
    m_count = 0;
    m_din   = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    int cnt_nx;
    int nxt;
    bit req [3];
    bit elig[3];
    req[0] = bus.req0;
    req[1] = bus.req1;
    req[2] = bus.req_rd;
    cnt_nx = m_count + ((m_grant < 2) ? 1 : 0) - ((m_grant == 2) ? 1 : 0);
    check("occupancy_in_range", (cnt_nx >= 0 && cnt_nx <= DEPTH), 1);
    elig[0] = req[0] && (cnt_nx < DEPTH) && (m_grant != 0);
    elig[1] = req[1] && (cnt_nx < DEPTH) && (m_grant != 1);
    elig[2] = req[2] && (cnt_nx > 0)     && (m_grant != 2);
    m_err = ERR_EN && (((req[0] || req[1]) && cnt_nx == DEPTH) || (req[2] && cnt_nx == 0));
    nxt = 3;
    for (int k = 1; k <= 3; k++) begin
      if (nxt == 3 && elig[(m_last + k) % 3]) nxt = (m_last + k) % 3;
    end
    if (nxt != 3) m_last = nxt;
    if (nxt == 0) m_din = bus.din0;
    if (nxt == 1) m_din = bus.din1;
    m_grant = nxt;
    m_count = cnt_nx;
  endtask

  task automatic compare_model();
    logic [11:0] act;
    logic [11:0] exp;
    act = {bus.gnt0, bus.gnt1, bus.gnt_rd, bus.fifo_wr_en, bus.fifo_rd_en,
           bus.full, bus.empty, bus.err, bus.count};
    exp = {m_grant == 0, m_grant == 1, m_grant == 2, m_grant < 2, m_grant == 2,
           m_count == DEPTH, m_count == 0, m_err, 4'(m_count)};
    check("model_outputs", act, exp);
    check("model_fifo_din", bus.fifo_din, m_din);
  endtask

  // One clock: model advances at the edge, DUT is sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
    n_g0  += int'(bus.gnt0);
    n_g1  += int'(bus.gnt1);
    n_grd += int'(bus.gnt_rd);
  endtask

  task automatic clear_reqs();
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.req_rd = 1'b0;
    bus.din0   = '0;
    bus.din1   = '0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    n_g0 = 0; n_g1 = 0; n_grd = 0;
  endtask

  typedef struct {
    bit          r0, r1, rr;
    logic [31:0] d0, d1;
    logic [2:0]  gnt;
    logic [3:0]  cnt;
    logic [31:0] din;
    bit          err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [DW-1:0] word;
    int            min_after_full;
    bit            seen_full;

    tbl[0]  = '{0, 0, 1, 32'h0,  32'h0,  3'b000, 4'd0, 32'h0,  1};
    tbl[1]  = '{1, 0, 0, 32'hA1, 32'h0,  3'b100, 4'd0, 32'hA1, 0};
    tbl[2]  = '{0, 0, 1, 32'h0,  32'h0,  3'b001, 4'd1, 32'hA1, 0};
    tbl[3]  = '{0, 0, 1, 32'h0,  32'h0,  3'b000, 4'd0, 32'hA1, 1};
    tbl[4]  = '{1, 1, 0, 32'hB0, 32'hB1, 3'b100, 4'd0, 32'hB0, 0};
    tbl[5]  = '{0, 1, 0, 32'h0,  32'hB1, 3'b010, 4'd1, 32'hB1, 0};
    tbl[6]  = '{0, 0, 1, 32'h0,  32'h0,  3'b001, 4'd2, 32'hB1, 0};
    tbl[7]  = '{0, 0, 0, 32'h0,  32'h0,  3'b000, 4'd1, 32'hB1, 0};
    tbl[8]  = '{0, 1, 1, 32'h0,  32'hC1, 3'b010, 4'd1, 32'hC1, 0};
    tbl[9]  = '{0, 0, 1, 32'h0,  32'h0,  3'b001, 4'd2, 32'hC1, 0};
    tbl[10] = '{0, 0, 0, 32'h0,  32'h0,  3'b000, 4'd1, 32'hC1, 0};
    tbl[11] = '{0, 0, 1, 32'h0,  32'h0,  3'b001, 4'd1, 32'hC1, 0};
    tbl[12] = '{0, 0, 1, 32'h0,  32'h0,  3'b000, 4'd0, 32'hC1, 1};

    clear_reqs();
    model_reset();
    apply_reset();
    check("reset_state",
          {bus.gnt0, bus.gnt1, bus.gnt_rd, bus.fifo_wr_en, bus.fifo_rd_en,
           bus.full, bus.empty, bus.err, bus.count},
          12'b00000_010_0000);
    check("reset_fifo_din", bus.fifo_din, 0);

    // Directed vectors from reset.
    for (int i = 0; i < 13; i++) begin
      bus.req0 = tbl[i].r0; bus.req1 = tbl[i].r1; bus.req_rd = tbl[i].rr;
      bus.din0 = tbl[i].d0; bus.din1 = tbl[i].d1;
      step();
      check($sformatf("tbl%0d_gnt", i), {bus.gnt0, bus.gnt1, bus.gnt_rd}, tbl[i].gnt);
      check($sformatf("tbl%0d_strobes", i), {bus.fifo_wr_en, bus.fifo_rd_en},
            {tbl[i].gnt[2] | tbl[i].gnt[1], tbl[i].gnt[0]});
      check($sformatf("tbl%0d_count", i), bus.count, tbl[i].cnt);
      check($sformatf("tbl%0d_din", i), bus.fifo_din, tbl[i].din);
      check($sformatf("tbl%0d_err", i), bus.err, tbl[i].err & ERR_EN);
    end

    // Asynchronous reset in the middle of a WR0 grant.
    apply_reset();
    bus.req0 = 1'b1; bus.din0 = 32'h55;
    step();
    check("pre_reset_gnt0", bus.gnt0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_grant",
          {bus.gnt0, bus.gnt1, bus.gnt_rd, bus.fifo_wr_en, bus.fifo_rd_en,
           bus.full, bus.empty, bus.err, bus.count},
          12'b00000_010_0000);
    check("rst_mid_fifo_din", bus.fifo_din, 0);
    clear_reqs();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Single writer fills the FIFO with 0x10..0x17.
    apply_reset();
    word = 32'h10;
    bus.req0 = 1'b1; bus.din0 = word;
    for (int c = 0; c < 24; c++) begin
      step();
      if (bus.gnt0) begin
        check("sw_data", bus.fifo_din, word);
        word = word + 1;
        bus.din0 = word;
      end
    end
    check("sw_grants", n_g0, 8);
    check("sw_count_full", {bus.count, bus.full, bus.empty}, {4'd8, 1'b1, 1'b0});

    // Two writers share fairly from empty.
    apply_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.din0 = 32'hAAAA; bus.din1 = 32'hBBBB;
    repeat (9) step();
    check("fair_w0", n_g0, 4);
    check("fair_w1", n_g1, 4);
    check("fair_full", {bus.count, bus.full}, {4'd8, 1'b1});

    // Three-way rotation: reach 4 entries, then all three request.
    apply_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (4) step();
    bus.req_rd = 1'b1;
    seen_full = 1'b0;
    min_after_full = DEPTH;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.full) seen_full = 1'b1;
      if (seen_full && int'(bus.count) < min_after_full) min_after_full = int'(bus.count);
    end
    check("rot_reached_full", seen_full, 1);
    check("rot_min_after_full", min_after_full, DEPTH - 1);

    // Read from empty is refused until a word exists.
    apply_reset();
    bus.req_rd = 1'b1;
    repeat (3) step();
    check("empty_no_rd", n_grd, 0);
    bus.req0 = 1'b1; bus.din0 = 32'h77;
    step();
    bus.req0 = 1'b0;
    repeat (4) step();
    check("empty_one_rd", n_grd, 1);
    check("empty_count", bus.count, 0);

    // Requester 1 withdraws after one cycle while W0 wins.
    apply_reset();
    bus.req0 = 1'b1; bus.din0 = 32'h1234;
    bus.req1 = 1'b1; bus.din1 = 32'hDEAD;
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) step();
    check("withdraw_no_gnt1", n_g1, 0);
    check("withdraw_count", bus.count, 1);

    // Randomized traffic against the model.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req0   = ($urandom_range(0, 3) != 0);
      bus.req1   = ($urandom_range(0, 2) != 0);
      bus.req_rd = ($urandom_range(0, 1) != 0);
      bus.din0   = $urandom;
      bus.din1   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_access_arb.md
# fifo_access_arb

Round-robin access scheduler for the 8-entry FIFO and its `fifo_ns` next-state logic. It shares the FIFO's single access per cycle between two write requesters and one read requester, and drives the FIFO's `wr_en`, `rd_en` and write data. A shadow occupancy counter guarantees the FIFO never sees a write when full or a read when empty, so the FIFO's WR_ERROR and RD_ERROR states are unreachable through this block.

## Interface
- `DATA_WIDTH`, 32, width of write data.
- `DEPTH`, 8, FIFO capacity in entries; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0` in 1: requester 0 has a word to write.
- `din0` in DATA_WIDTH: requester 0 write data.
- `req1` in 1: requester 1 has a word to write.
- `din1` in DATA_WIDTH: requester 1 write data.
- `req_rd` in 1: consumer wants to pop one word.
- `gnt0`, `gnt1`, `gnt_rd` out 1: one-cycle grant pulses; at most one is high per cycle.
- `fifo_wr_en` out 1: write strobe to the FIFO.
- `fifo_rd_en` out 1: read strobe to the FIFO.
- `fifo_din` out DATA_WIDTH: write data to the FIFO.
- `count` out 4: shadow occupancy.
- `full` out 1: high when `count == DEPTH`.
- `empty` out 1: high when `count == 0`.
- `err` out 1: blocked-request pulse (see Configuration).

## Operation
- **States:** IDLE, WR0, WR1, RD. The state register is the grant currently being driven.
  - WR0: `gnt0 = fifo_wr_en = 1`, `fifo_din = registered din0`.
  - WR1: same as WR0 with requester 1.
  - RD: `gnt_rd = fifo_rd_en = 1`.
  - IDLE: all strobes 0; `fifo_din` holds its last value.
- **Eligibility**, evaluated at each rising edge:
  - W0 is eligible when `req0 & ~full_next & state != WR0`.
  - W1 is eligible when `req1 & ~full_next & state != WR1`.
  - RD is eligible when `req_rd & ~empty_next & state != RD`.
  - `*_next` terms use the occupancy after the access currently being issued.
  - The `state != own` term means a requester is never granted in two consecutive cycles. A lone requester therefore gets at most every other cycle.
- **Round-robin:** `last` holds the most recently granted requester (reset value RD). The search order starts after `last` in the cycle W0, W1, RD, W0. The first eligible requester becomes the next state; if none is eligible, the next state is IDLE. `last` updates only on a grant.
- **Counter:**
  - +1 on each cycle in WR0 or WR1.
  - −1 on each cycle in RD.
  - A simultaneous write and read is impossible because only one access happens per cycle.
  - Saturation is never needed; an overflow or underflow is a design bug and must be asserted in the bench.
- **Reset:** state IDLE, `last` = RD, `count` = 0, `full` = 0, `empty` = 1. All grants, strobes and `err` are 0, and `fifo_din` is 0. An asserted `reset_n` clears these immediately, even in the middle of a grant.

## Timing
- A request sampled at edge N produces a grant, strobe and data during cycle N..N+1. Latency is 1 cycle minimum.
- All outputs are registered, with no combinational path from input to output.
- **Requester handshake:**
  - The requester holds `req`/`din` stable until it sees `gnt` high.
  - At the edge that ends the `gnt` cycle, it either drops `req` or presents the next word.
  - Dropping `req` before a grant withdraws the request with no side effects.
- `count`, `full` and `empty` reflect every access whose strobe cycle has completed. They update at the same edge that ends the strobe.
- **Boundaries:**
  - When `count == DEPTH - 1` and a write is in flight, no further write is granted.
  - When `count == 1` and a read is in flight, no further read is granted.
  - Neither condition blocks the opposite direction.

## Configuration
- `FIFO_ACCESS_ARB_ERR_EN`: when defined, `err` pulses high for one cycle whenever either of these holds at a rising edge:
  - `req0` or `req1` is high while `full_next` is true, or
  - `req_rd` is high while `empty_next` is true.
- When not defined, `err` is tied to 0 and no detection logic is generated. All other behaviour is identical.

## Test plan
- **Reset:** assert `reset_n = 0` mid-WR0 → all outputs are at reset values immediately. `count` = 0, `empty` = 1.
- **Single writer:** hold `req0` = 1 with `din0` incrementing from 0x10 → `gnt0` pulses every other cycle. Writes 0x10..0x17 land and `count` reaches 8 with `full` = 1. No further `gnt0` is issued, and `err` pulses each cycle when `FIFO_ACCESS_ARB_ERR_EN` is defined.
- **Fair write sharing:** `req0` = `req1` = 1 continuously from empty → grants alternate W0, W1, W0, ... with 8 writes in 8 cycles, 4 from each requester.
- **Three-way rotation:** start at `count` = 4 and hold all three requests → the grant sequence is W0, W1, RD repeating. `count` climbs by +1 net every 3 cycles until it reaches 8. After that only RD and the writers alternate, keeping the FIFO between 7 and 8 entries.
- **Empty read:** `req_rd` = 1 at `count` = 0 → no `gnt_rd` and no `fifo_rd_en`. After a single write, exactly one `gnt_rd` follows and `count` returns to 0.
- **Withdrawn request:** pulse `req1` for one cycle while W0 is being granted → no `gnt1`, no write from requester 1, and `count` is unaffected.
